generate_data_packet_stream: RTL and testbench

- Parametrised successor to the fixed 26-word test-packet generator.
- Emits framed test packets: header, N payload words, optional checksum, footer.
- Adds a valid/ready handshake, runtime payload length, inter-packet gap, pattern modes and a packet counter.
- Sits between the user-module test logic and the readout FIFO/link path as a deterministic data source.

---
 rtl/generate_data_packet_stream.sv | 225 ++++++++++++++++++++++
 tb/tb_generate_data_packet_stream.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/generate_data_packet_stream.sv
// rtl/generate_data_packet_stream.sv - framed test-packet source with valid/ready handshake
// Optional checksum word enabled by defining GENERATE_DATA_PACKET_CHECKSUM_EN.
module generate_data_packet_stream #(
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] HEADER_WORD = 32'hAAAAAAAA,
    parameter logic [31:0] FOOTER_WORD = 32'hF0F0F0F0,
    parameter int          LEN_WIDTH   = 8,
    parameter logic [31:0] CONST_WORD  = 32'h5A5A5A5A
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENABLE,
    input  logic [LEN_WIDTH-1:0]  PAYLOAD_LEN,
    input  logic [LEN_WIDTH-1:0]  GAP_LEN,
    input  logic [1:0]            MODE,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  DATA_VALID,
    input  logic                  DATA_READY,
    output logic                  SOP,
    output logic                  EOP,
    output logic [31:0]           PKT_COUNT
);

    localparam int H = DATA_WIDTH / 2;
    localparam logic [DATA_WIDTH-1:0] HDR_W   = DATA_WIDTH'(HEADER_WORD);
    localparam logic [DATA_WIDTH-1:0] FTR_W   = DATA_WIDTH'(FOOTER_WORD);
    localparam logic [DATA_WIDTH-1:0] CONST_W = DATA_WIDTH'(CONST_WORD);

    // State names the word currently presented on DATA_OUT.
    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
`ifdef GENERATE_DATA_PACKET_CHECKSUM_EN
        S_CHECKSUM,
`endif
        S_FOOTER,
        S_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  sop_q, sop_d;
    logic                  eop_q, eop_d;
    logic [31:0]           pkt_q, pkt_d;
    logic [H-1:0]          ramp_q, ramp_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  gap_q, gap_d;
    logic [1:0]            mode_q, mode_d;
`ifdef GENERATE_DATA_PACKET_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
`endif

    logic                  accept;
    logic                  start;
    logic [H-1:0]          ramp_adv;

    // Payload word for a given ramp value; constant mode ignores the ramp.
    function automatic logic [DATA_WIDTH-1:0] payload_word(input logic [H-1:0] r,
                                                           input logic [1:0]   m);
        if (m == 2'd2) begin
            return CONST_W;
        end
        return {r + H'(1), r};
    endfunction

    // Next-state and next-output computation; outputs only move on an accepted word or packet start.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        valid_d  = valid_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        pkt_d    = pkt_q;
        ramp_d   = ramp_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        gap_d    = gap_q;
        mode_d   = mode_q;
`ifdef GENERATE_DATA_PACKET_CHECKSUM_EN
        acc_d    = acc_q;
`endif
        start    = 1'b0;
        ramp_adv = (mode_q == 2'd2) ? ramp_q : ramp_q + H'(2);
        accept   = valid_q & DATA_READY;

        case (state_q)
            S_IDLE: begin
                if (ENABLE) begin
                    start = 1'b1;
                end
            end
            S_HEADER: begin
                if (accept) begin
                    state_d = S_PAYLOAD;
                    sop_d   = 1'b0;
                    cnt_d   = '0;
                    data_d  = payload_word(ramp_q, mode_q);
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    ramp_d = ramp_adv;
`ifdef GENERATE_DATA_PACKET_CHECKSUM_EN
                    acc_d  = acc_q ^ data_q;
`endif
                    if (cnt_q == len_q - LEN_WIDTH'(1)) begin
`ifdef GENERATE_DATA_PACKET_CHECKSUM_EN
                        state_d = S_CHECKSUM;
                        data_d  = acc_q ^ data_q;
`else
                        state_d = S_FOOTER;
                        data_d  = FTR_W;
                        eop_d   = 1'b1;
`endif
                    end else begin
                        cnt_d  = cnt_q + LEN_WIDTH'(1);
                        data_d = payload_word(ramp_adv, mode_q);
                    end
                end
            end
`ifdef GENERATE_DATA_PACKET_CHECKSUM_EN
            S_CHECKSUM: begin
                if (accept) begin
                    state_d = S_FOOTER;
                    data_d  = FTR_W;
                    eop_d   = 1'b1;
                end
            end
`endif
            S_FOOTER: begin
                if (accept) begin
                    pkt_d = pkt_q + 32'd1;
                    eop_d = 1'b0;
                    if (!ENABLE) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                    end else if (GAP_LEN == '0) begin
                        start = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        valid_d = 1'b0;
                        gap_d   = GAP_LEN - LEN_WIDTH'(1);
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    if (ENABLE) begin
                        start = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q - LEN_WIDTH'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Packet start: present the header and capture this packet's length and mode.
        if (start) begin
            state_d = S_HEADER;
            valid_d = 1'b1;
            data_d  = HDR_W;
            sop_d   = 1'b1;
            eop_d   = 1'b0;
            len_d   = (PAYLOAD_LEN == '0) ? LEN_WIDTH'(1) : PAYLOAD_LEN;
            mode_d  = MODE;
            if (MODE == 2'd0 || MODE == 2'd3) begin
                ramp_d = '0;
            end
`ifdef GENERATE_DATA_PACKET_CHECKSUM_EN
            acc_d   = '0;
`endif
        end
    end

    // State and registered outputs; reset aborts any packet in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            pkt_q   <= '0;
            ramp_q  <= '0;
            cnt_q   <= '0;
            len_q   <= LEN_WIDTH'(1);
            gap_q   <= '0;
            mode_q  <= 2'd0;
`ifdef GENERATE_DATA_PACKET_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            pkt_q   <= pkt_d;
            ramp_q  <= ramp_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            mode_q  <= mode_d;
`ifdef GENERATE_DATA_PACKET_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign DATA_OUT   = data_q;
    assign DATA_VALID = valid_q;
    assign SOP        = sop_q;
    assign EOP        = eop_q;
    assign PKT_COUNT  = pkt_q;

endmodule

// File: tb/tb_generate_data_packet_stream.sv
// tb/tb_generate_data_packet_stream.sv - self-checking bench for generate_data_packet_stream
module tb_generate_data_packet_stream;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ENABLE = 1'b0;
    logic [7:0]  PAYLOAD_LEN = 8'd0;
    logic [7:0]  GAP_LEN = 8'd0;
    logic [1:0]  MODE = 2'd0;
    logic [31:0] DATA_OUT;
    logic        DATA_VALID;
    logic        DATA_READY = 1'b0;
    logic        SOP;
    logic        EOP;
    logic [31:0] PKT_COUNT;

`ifdef GENERATE_DATA_PACKET_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam logic [31:0] HDR = 32'hAAAAAAAA;
    localparam logic [31:0] FTR = 32'hF0F0F0F0;
    localparam logic [31:0] CST = 32'h5A5A5A5A;

    generate_data_packet_stream dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .PAYLOAD_LEN(PAYLOAD_LEN),
        .GAP_LEN(GAP_LEN), .MODE(MODE), .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID),
        .DATA_READY(DATA_READY), .SOP(SOP), .EOP(EOP), .PKT_COUNT(PKT_COUNT)
    );

    always #5 CLK = ~CLK;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [31:0] d;
        bit          s;
        bit          e;
    } word_t;

    typedef struct {
        int          len;
        int          mode;
        int          n;
        logic [31:0] pay [4];
    } vec_t;

    word_t exp_q[$];

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset(input int len, input int mode, input int gap, input bit en, input bit rdy);
        @(posedge CLK); #1;
        RST = 1'b1;
        PAYLOAD_LEN = 8'(len);
        MODE = 2'(mode);
        GAP_LEN = 8'(gap);
        ENABLE = en;
        DATA_READY = rdy;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    // Reference stream: header, payload by ramp arithmetic, optional XOR checksum, footer.
    function automatic void build(input int npk, input int len, input int mode);
        int ramp = 0;
        int l = (len == 0) ? 1 : len;
        logic [31:0] w, x;
        for (int p = 0; p < npk; p++) begin
            if (mode == 0 || mode == 3) ramp = 0;
            exp_q.push_back('{HDR, 1'b1, 1'b0});
            x = 32'h0;
            for (int k = 0; k < l; k++) begin
                w = (mode == 2) ? CST : {16'(ramp + 1), 16'(ramp)};
                x = x ^ w;
                exp_q.push_back('{w, 1'b0, 1'b0});
                if (mode != 2) ramp = ramp + 2;
            end
            if (CS != 0) exp_q.push_back('{x, 1'b0, 1'b0});
            exp_q.push_back('{FTR, 1'b0, 1'b1});
        end
    endfunction

    // Drives a run from reset and scores every accepted word, hold stability, gaps and packet count.
    task automatic run_stream(input int npk, input int len, input int mode, input int gap, input int rdy_pct);
        word_t w, held;
        int cyc = 0, pkts = 0, gap_run = -1, first_v = -1;
        bit hold = 0, pkt_pend = 0;
        exp_q.delete();
        build(npk, len, mode);
        do_reset(len, mode, gap, 1'b1, 1'b1);
        while (exp_q.size() > 0 && cyc < 3000) begin
            @(negedge CLK);
            if (pkt_pend) begin
                check_eq("pkt_count", PKT_COUNT, pkts);
                pkt_pend = 0;
            end
            if (hold) begin
                check_eq("hold_stable", {DATA_VALID, SOP, EOP, DATA_OUT}, {1'b1, held.s, held.e, held.d});
                hold = 0;
            end
            if (DATA_VALID) begin
                if (first_v < 0) begin
                    first_v = cyc;
                    check_eq("start_latency", cyc, 1);
                end
                if (gap_run >= 0) begin
                    check_eq("gap_cycles", gap_run, gap);
                    gap_run = -1;
                end
                if (DATA_READY) begin
                    w = exp_q.pop_front();
                    check_eq("stream_word", {SOP, EOP, DATA_OUT}, {w.s, w.e, w.d});
                    if (w.e) begin
                        pkts++;
                        pkt_pend = 1;
                        gap_run = 0;
                    end
                end else begin
                    hold = 1;
                    held = '{DATA_OUT, SOP, EOP};
                end
            end else if (gap_run >= 0) begin
                gap_run++;
            end
            cyc++;
            @(posedge CLK); #1;
            DATA_READY = ($urandom_range(0, 99) < rdy_pct);
        end
        check_eq("stream_complete", exp_q.size(), 0);
        @(negedge CLK);
        if (pkt_pend) check_eq("pkt_count", PKT_COUNT, pkts);
        ENABLE = 1'b0;
    endtask

    function automatic vec_t mk(input int len, input int mode, input int n,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3);
        vec_t v;
        v.len = len; v.mode = mode; v.n = n;
        v.pay[0] = w0; v.pay[1] = w1; v.pay[2] = w2; v.pay[3] = w3;
        return v;
    endfunction

    initial begin
        vec_t tbl[5];
        word_t got[$];
        logic [31:0] x;
        int cyc, n;

        tbl[0] = mk(0, 0, 1, 32'h00010000, 32'h0, 32'h0, 32'h0);
        tbl[1] = mk(3, 0, 3, 32'h00010000, 32'h00030002, 32'h00050004, 32'h0);
        tbl[2] = mk(2, 2, 2, CST, CST, 32'h0, 32'h0);
        tbl[3] = mk(2, 3, 2, 32'h00010000, 32'h00030002, 32'h0, 32'h0);
        tbl[4] = mk(4, 1, 4, 32'h00010000, 32'h00030002, 32'h00050004, 32'h00070006);

        // Reset state
        repeat (3) @(negedge CLK);
        check_eq("reset_outputs", {DATA_VALID, SOP, EOP, DATA_OUT}, 35'h0);
        check_eq("reset_pkt_count", PKT_COUNT, 0);

        // Table: first packet of each configuration with READY held high
        for (int t = 0; t < 5; t++) begin
            do_reset(tbl[t].len, tbl[t].mode, 0, 1'b1, 1'b1);
            got.delete();
            n = tbl[t].n + 2 + CS;
            cyc = 0;
            while (got.size() < n && cyc < 60) begin
                @(negedge CLK);
                if (DATA_VALID && DATA_READY) got.push_back('{DATA_OUT, SOP, EOP});
                cyc++;
            end
            ENABLE = 1'b0;
            check_eq("tbl_word_count", got.size(), n);
            if (got.size() == n) begin
                check_eq("tbl_header", {got[0].s, got[0].e, got[0].d}, {1'b1, 1'b0, HDR});
                x = 32'h0;
                for (int k = 0; k < tbl[t].n; k++) begin
                    check_eq("tbl_payload", {got[k+1].s, got[k+1].e, got[k+1].d}, {2'b00, tbl[t].pay[k]});
                    x = x ^ tbl[t].pay[k];
                end
                if (CS != 0) check_eq("tbl_checksum", got[n-2].d, x);
                check_eq("tbl_footer", {got[n-1].s, got[n-1].e, got[n-1].d}, {1'b0, 1'b1, FTR});
            end
        end

        // Default stream: 3 packets of 24, back-to-back, PKT_COUNT reaches 3
        run_stream(3, 24, 0, 0, 100);
        // Continuous ramp across packets with a 2-cycle gap
        run_stream(3, 2, 1, 2, 100);
        // Zero length treated as one word
        run_stream(2, 0, 0, 1, 100);

        // Backpressure: stall 3 cycles on 00050004
        do_reset(24, 0, 0, 1'b1, 1'b1);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!(DATA_VALID && DATA_OUT == 32'h00030002) && cyc < 40);
        check_eq("bp_reach", DATA_OUT, 32'h00030002);
        @(posedge CLK); #1 DATA_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check_eq("bp_hold", {DATA_VALID, DATA_OUT}, {1'b1, 32'h00050004});
            if (i == 2) begin
                @(posedge CLK); #1 DATA_READY = 1'b1;
            end
        end
        @(negedge CLK);
        check_eq("bp_next", {DATA_VALID, DATA_OUT}, {1'b1, 32'h00070006});
        ENABLE = 1'b0;

        // Reset in the middle of the second packet's payload
        do_reset(24, 0, 0, 1'b1, 1'b1);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!(PKT_COUNT == 32'd1 && DATA_VALID && DATA_OUT == 32'h000B000A) && cyc < 100);
        check_eq("rst_pre_count", PKT_COUNT, 1);
        RST = 1'b1;
        @(negedge CLK);
        check_eq("rst_mid_outputs", {DATA_VALID, SOP, EOP, DATA_OUT}, 35'h0);
        check_eq("rst_mid_count", PKT_COUNT, 0);
        RST = 1'b0;
        @(negedge CLK);
        check_eq("rst_header", {DATA_VALID, SOP, DATA_OUT}, {2'b11, HDR});
        @(negedge CLK);
        check_eq("rst_first_payload", {DATA_VALID, DATA_OUT}, {1'b1, 32'h00010000});
        ENABLE = 1'b0;

        // Randomised configurations and backpressure against the reference model
        for (int r = 0; r < 6; r++) begin
            run_stream(3, $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3),
                       (r % 3 == 0) ? 100 : ((r % 3 == 1) ? 70 : 40));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
